// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : noc_pkg
// Purpose  : Shared NoC definitions for the traffic generator, router and
//            main. Holds the opcode encoding, the bit positions of the fields
//            carried on the 32-bit command word, the bit positions of the
//            fields in the presented-flit buffer, and a saturating-increment
//            helper.
// Revision : 1.0 - initial release
// ============================================================================
package noc_pkg;

    // Command opcodes; any other 4-bit code behaves as NOP.
    typedef enum logic [3:0] {
        OP_NOP     = 4'd0,
        OP_INIT    = 4'd5,
        OP_FILL    = 4'd6,
        OP_DEQUEUE = 4'd7,
        OP_PREDEQ  = 4'd8
    } op_e;

    // Command word layout.
    localparam int DATA_W    = 32;
    localparam int TOTAL_LSB = 22;   // Init: expected packet total
    localparam int TOTAL_W   = 10;
    localparam int DST_LSB   = 0;    // Fill: destination
    localparam int VC_LSB    = 14;   // Fill: virtual channel
    localparam int NFLIT_LSB = 17;   // Fill: flit count

    // Presented-flit buffer layout.
    localparam int BUF_FULL    = 0;
    localparam int BUF_VC_LSB  = 1;
    localparam int BUF_HEAD    = 4;
    localparam int BUF_TAIL    = 5;
    localparam int BUF_DST_LSB = 6;
    localparam int BUF_W       = 20;

    // Counter increment that sticks at all-ones.
    function automatic logic [TOTAL_W-1:0] sat_inc(input logic [TOTAL_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/packet_fifo.sv
`default_nettype none
// ============================================================================
// Module   : packet_fifo
// Purpose  : Single-clock packet-descriptor queue. Pointers wrap modulo DEPTH
//            and a separate occupancy count tells full from empty. Exposes the
//            head entry and the entry behind it, so the consumer can move
//            straight on to the next packet in the same cycle it pops.
// Ports    : clk, rst_n (async, active-low)
//            clr_i    - synchronous flush of pointers and occupancy
//            push_i   - write din_i at the tail (ignored when full)
//            pop_i    - drop the head entry (ignored when empty)
//            din_i    - descriptor to push
//            full_o   - occupancy == DEPTH
//            empty_o  - occupancy == 0
//            multi_o  - occupancy >= 2 (next_o is valid)
//            head_o   - entry at the head
//            next_o   - entry behind the head
// Revision : 1.0 - initial release
// ============================================================================
module packet_fifo #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 27
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             full_o,
    output logic             empty_o,
    output logic             multi_o,
    output logic [WIDTH-1:0] head_o,
    output logic [WIDTH-1:0] next_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] C_LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] C_DEPTH    = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    // Explicit wrap so non-power-of-two depths behave.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == C_LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == C_DEPTH);
    assign empty_o = (count_q == '0);
    assign multi_o = (count_q > CNT_W'(1));
    assign head_o  = mem_q[rd_ptr_q];
    assign next_o  = mem_q[ptr_inc(rd_ptr_q)];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is read until it has been written.
    always_ff @(posedge clk) begin
        if (push_ok && !clr_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/traffic_gen.sv
`default_nettype none
// ============================================================================
// Module   : traffic_gen
// Purpose  : NoC traffic generator. Packet descriptors are queued by Fill and
//            emitted flit by flit into a one-flit presentation buffer driven
//            by PreDeque/Dequeue. done flags that the expected number of
//            packets has been fully emitted.
// Ports    : clk, rst_n (async, active-low)
//            op     [3:0]  - opcode (NOP/Init/Fill/Dequeue/PreDeque)
//            data   [31:0] - command payload
//            done          - sent == total and no flit presented
//            buffer [19:0] - presented flit {Dst, Tail, Head, Vc, Full}
// Revision : 1.0 - initial release
// ============================================================================
module traffic_gen
    import noc_pkg::*;
#(
    parameter int NUM_PACKETS = 1024,
    parameter int DEST_W      = 14,
    parameter int VC_W        = 3,
    parameter int FLIT_W      = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] data,
    output logic              done,
    output logic [BUF_W-1:0]  buffer
);

    // Descriptor layout inside the queue: {dst, vc, nflit}.
    localparam int DESC_W = DEST_W + VC_W + FLIT_W;

    op_e                op_s;

    logic [TOTAL_W-1:0] total_q,    total_d;
    logic [TOTAL_W-1:0] sent_q,     sent_d;
    logic [FLIT_W-1:0]  flit_cnt_q, flit_cnt_d;
    logic [FLIT_W-1:0]  nflit_q,    nflit_d;    // effective (>=1) length of current packet
    logic               full_q,     full_d;
    logic               head_q,     head_d;
    logic               tail_q,     tail_d;
    logic [VC_W-1:0]    vc_q,       vc_d;
    logic [DEST_W-1:0]  dst_q,      dst_d;
    logic               done_q,     done_d;

    logic               fifo_clr;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_multi;
    logic [DESC_W-1:0]  fifo_head;
    logic [DESC_W-1:0]  fifo_next;
    logic [DESC_W-1:0]  fill_desc;

    logic               load_en;
    logic [DESC_W-1:0]  load_desc;
    logic [FLIT_W-1:0]  load_nflit;
    logic [FLIT_W-1:0]  flit_inc;

    assign op_s      = op_e'(op);
    assign fill_desc = {data[DST_LSB +: DEST_W], data[VC_LSB +: VC_W], data[NFLIT_LSB +: FLIT_W]};
    assign flit_inc  = flit_cnt_q + 1'b1;

    // A zero flit count describes a single-flit packet.
    assign load_nflit = (load_desc[FLIT_W-1:0] == '0) ? FLIT_W'(1) : load_desc[FLIT_W-1:0];

    packet_fifo #(
        .DEPTH (NUM_PACKETS),
        .WIDTH (DESC_W)
    ) u_packet_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (fifo_clr),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   (fill_desc),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .multi_o (fifo_multi),
        .head_o  (fifo_head),
        .next_o  (fifo_next)
    );

    always_comb begin
        total_d    = total_q;
        sent_d     = sent_q;
        flit_cnt_d = flit_cnt_q;
        nflit_d    = nflit_q;
        full_d     = full_q;
        head_d     = head_q;
        tail_d     = tail_q;
        vc_d       = vc_q;
        dst_d      = dst_q;
        fifo_clr   = 1'b0;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        load_en    = 1'b0;
        load_desc  = fifo_head;

        case (op_s)
            OP_INIT: begin
                total_d    = data[TOTAL_LSB +: TOTAL_W];
                sent_d     = '0;
                fifo_clr   = 1'b1;
                flit_cnt_d = '0;
                nflit_d    = '0;
                full_d     = 1'b0;
                head_d     = 1'b0;
                tail_d     = 1'b0;
                vc_d       = '0;
                dst_d      = '0;
            end
            OP_FILL: begin
                fifo_push = !fifo_full;
            end
            OP_PREDEQ: begin
                if (!full_q && !fifo_empty) begin
                    load_en = 1'b1;
                end
            end
            OP_DEQUEUE: begin
                if (full_q && !tail_q) begin
                    flit_cnt_d = flit_inc;
                    head_d     = 1'b0;
                    tail_d     = (flit_inc == nflit_q);
                end else if (full_q) begin
                    // The presented packet stays at the queue head until its
                    // tail is consumed; its successor sits one slot behind.
                    fifo_pop = 1'b1;
                    sent_d   = sat_inc(sent_q);
                    if (fifo_multi) begin
                        load_en   = 1'b1;
                        load_desc = fifo_next;
                    end else begin
                        flit_cnt_d = '0;
                        nflit_d    = '0;
                        full_d     = 1'b0;
                        head_d     = 1'b0;
                        tail_d     = 1'b0;
                        vc_d       = '0;
                        dst_d      = '0;
                    end
                end
            end
            default: begin
            end
        endcase

        if (load_en) begin
            full_d     = 1'b1;
            head_d     = 1'b1;
            nflit_d    = load_nflit;
            tail_d     = (load_nflit == FLIT_W'(1));
            flit_cnt_d = FLIT_W'(1);
            vc_d       = load_desc[FLIT_W +: VC_W];
            dst_d      = load_desc[FLIT_W + VC_W +: DEST_W];
        end

        done_d = (sent_d == total_d) && !full_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_q    <= '0;
            sent_q     <= '0;
            flit_cnt_q <= '0;
            nflit_q    <= '0;
            full_q     <= 1'b0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            vc_q       <= '0;
            dst_q      <= '0;
            done_q     <= 1'b1;
        end else begin
            total_q    <= total_d;
            sent_q     <= sent_d;
            flit_cnt_q <= flit_cnt_d;
            nflit_q    <= nflit_d;
            full_q     <= full_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            vc_q       <= vc_d;
            dst_q      <= dst_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        buffer                          = '0;
        buffer[BUF_FULL]                = full_q;
        buffer[BUF_VC_LSB +: VC_W]      = vc_q;
        buffer[BUF_HEAD]                = head_q;
        buffer[BUF_TAIL]                = tail_q;
        buffer[BUF_DST_LSB +: DEST_W]   = dst_q;
    end

    assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_gen
// Purpose  : Self-checking bench for traffic_gen. A queue-based model tracks
//            the outstanding packets and the index of the presented flit;
//            buffer/done are compared against it every cycle, and directed
//            scenarios add hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_gen;

    localparam logic [3:0] C_NOP  = 4'd0;
    localparam logic [3:0] C_INIT = 4'd5;
    localparam logic [3:0] C_FILL = 4'd6;
    localparam logic [3:0] C_DEQ  = 4'd7;
    localparam logic [3:0] C_PRE  = 4'd8;
    localparam int         C_QCAP = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  op;
    logic [31:0] data;
    logic        done;
    logic [19:0] buffer;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    traffic_gen #(
        .NUM_PACKETS (1024),
        .DEST_W      (14),
        .VC_W        (3),
        .FLIT_W      (10)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .op     (op),
        .data   (data),
        .done   (done),
        .buffer (buffer)
    );

    // ------------------------------------------------------------ model
    typedef struct {
        int dst;
        int vc;
        int nf;
    } desc_t;

    desc_t mq[$];
    int    m_total;
    int    m_sent;
    int    m_flit;   // 1-based index of the presented flit of mq[0]
    bit    m_pres;

    function automatic int eff_nf(input int nf);
        return (nf == 0) ? 1 : nf;
    endfunction

    function automatic logic [19:0] exp_buf();
        desc_t e;
        int    en;
        if (!m_pres) return 20'h0;
        e  = mq[0];
        en = eff_nf(e.nf);
        return {e.dst[13:0], (m_flit == en), (m_flit == 1), e.vc[2:0], 1'b1};
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_total = 0;
                m_sent  = 0;
                m_flit  = 0;
                m_pres  = 1'b0;
            end else begin
                case (op)
                    C_INIT: begin
                        mq.delete();
                        m_total = int'(data[31:22]);
                        m_sent  = 0;
                        m_flit  = 0;
                        m_pres  = 1'b0;
                    end
                    C_FILL: begin
                        desc_t d;
                        d.dst = int'(data[13:0]);
                        d.vc  = int'(data[16:14]);
                        d.nf  = int'(data[26:17]);
                        if (mq.size() < C_QCAP) mq.push_back(d);
                    end
                    C_PRE: begin
                        if (!m_pres && mq.size() > 0) begin
                            m_pres = 1'b1;
                            m_flit = 1;
                        end
                    end
                    C_DEQ: begin
                        if (m_pres) begin
                            if (m_flit < eff_nf(mq[0].nf)) begin
                                m_flit++;
                            end else begin
                                void'(mq.pop_front());
                                if (m_sent < 1023) m_sent++;
                                if (mq.size() > 0) begin
                                    m_flit = 1;
                                end else begin
                                    m_pres = 1'b0;
                                    m_flit = 0;
                                end
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------ compare
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                checks++;
                if (buffer !== exp_buf()) begin
                    failures++;
                    $display("FAIL model_buffer t=%0t got=%05h expected=%05h", $time, buffer, exp_buf());
                end
                checks++;
                if (done !== ((m_sent == m_total) && !m_pres)) begin
                    failures++;
                    $display("FAIL model_done t=%0t got=%0b expected=%0b", $time, done,
                             ((m_sent == m_total) && !m_pres));
                end
            end
        end
    end

    // ------------------------------------------------------------ helpers
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] o, input logic [31:0] d);
        op   = o;
        data = d;
        @(negedge clk);
    endtask

    function automatic logic [31:0] fw(input int dst, input int vc, input int nf);
        logic [31:0] w;
        w        = '0;
        w[13:0]  = dst[13:0];
        w[16:14] = vc[2:0];
        w[26:17] = nf[9:0];
        return w;
    endfunction

    function automatic logic [31:0] iw(input int total);
        logic [31:0] w;
        w        = '0;
        w[31:22] = total[9:0];
        return w;
    endfunction

    // ------------------------------------------------------------ stimulus
    initial begin
        int heads;
        int cnt;
        rst_n  = 1'b0;
        op     = C_NOP;
        data   = '0;
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_buffer", 32'(buffer), 32'h0);
        check("reset_done", 32'(done), 32'h1);
        rst_n = 1'b1;

        // Three-flit packet, total 1.
        step(C_INIT, iw(1));
        check("t1_done_after_init", 32'(done), 32'h0);
        step(C_FILL, fw(3, 2, 3));
        step(C_PRE, 32'h0);
        check("t1_head_flit", 32'(buffer), 32'h000D5);
        step(C_DEQ, 32'h0);
        check("t1_body_flit", 32'(buffer), 32'h000C5);
        step(C_DEQ, 32'h0);
        check("t1_tail_flit", 32'(buffer), 32'h000E5);
        check("t1_done_mid", 32'(done), 32'h0);
        step(C_DEQ, 32'h0);
        check("t1_empty", 32'(buffer), 32'h0);
        check("t1_done_end", 32'(done), 32'h1);

        // Single-flit then two-flit packet, total 2.
        step(C_INIT, iw(2));
        step(C_FILL, fw(1, 0, 1));
        step(C_FILL, fw(5, 0, 2));
        step(C_PRE, 32'h0);
        check("t2_single", 32'(buffer), 32'h00071);
        step(C_DEQ, 32'h0);
        check("t2_next_head", 32'(buffer), 32'h00151);
        check("t2_done_mid", 32'(done), 32'h0);
        step(C_DEQ, 32'h0);
        check("t2_next_tail", 32'(buffer), 32'h00161);
        check("t2_done_tail", 32'(done), 32'h0);
        step(C_DEQ, 32'h0);
        check("t2_done_end", 32'(done), 32'h1);

        // Zero total.
        step(C_INIT, iw(0));
        check("t3_done", 32'(done), 32'h1);
        step(C_DEQ, 32'h0);
        check("t3_deq_buf", 32'(buffer), 32'h0);
        step(C_PRE, 32'h0);
        check("t3_pre_buf", 32'(buffer), 32'h0);

        // Idle Dequeue, undefined opcodes, Fill while presenting, NumFlit=0.
        step(C_INIT, iw(1));
        step(C_FILL, fw(7, 1, 2));
        step(C_DEQ, 32'h0);
        check("t4_idle_deq", 32'(buffer), 32'h0);
        step(4'd3, 32'hFFFF_FFFF);
        check("t4_op3_buf", 32'(buffer), 32'h0);
        check("t4_op3_done", 32'(done), 32'h0);
        step(C_PRE, 32'h0);
        check("t4_head", 32'(buffer), 32'h001D3);
        step(4'd4, 32'h1234_5678);
        check("t4_op4_buf", 32'(buffer), 32'h001D3);
        step(C_FILL, fw(9, 5, 0));
        check("t4_fill_hold", 32'(buffer), 32'h001D3);
        step(C_DEQ, 32'h0);
        check("t4_tail", 32'(buffer), 32'h001E3);
        step(C_DEQ, 32'h0);
        check("t4_nf0", 32'(buffer), 32'h0027B);
        check("t4_done_pres", 32'(done), 32'h0);
        step(C_DEQ, 32'h0);
        check("t4_over_total", 32'(done), 32'h0);

        // Reset mid-packet.
        step(C_INIT, iw(1));
        step(C_FILL, fw(4, 0, 3));
        step(C_PRE, 32'h0);
        step(C_DEQ, 32'h0);
        op = C_NOP;
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_buf", 32'(buffer), 32'h0);
        check("t5_async_done", 32'(done), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        step(C_PRE, 32'h0);
        check("t5_pre_after_rst", 32'(buffer), 32'h0);

        // Queue capacity and pointer wrap.
        step(C_INIT, iw(1023));
        for (int i = 0; i < 5; i++) step(C_FILL, fw(i + 20, 1, 2));
        step(C_PRE, 32'h0);
        for (int i = 0; i < 10; i++) step(C_DEQ, 32'h0);
        check("t6_pre_drain", 32'(buffer), 32'h0);
        for (int i = 0; i <= C_QCAP; i++) step(C_FILL, fw(i, i % 8, i % 2));
        step(C_PRE, 32'h0);
        check("t6_first", 32'(buffer), 32'h00031);
        heads = 0;
        cnt   = 0;
        while (buffer[0] === 1'b1 && cnt < 1100) begin
            if (buffer[4] === 1'b1) heads++;
            step(C_DEQ, 32'h0);
            cnt++;
        end
        check("t6_drain_bounded", 32'(cnt < 1100), 32'h1);
        check("t6_heads", 32'(heads), 32'd1024);
        check("t6_empty", 32'(buffer), 32'h0);
        check("t6_done_sat", 32'(done), 32'h1);
        step(C_FILL, fw(100, 3, 2));
        step(C_FILL, fw(200, 4, 1));
        step(C_PRE, 32'h0);
        check("t6_wrap_head", 32'(buffer), 32'h01917);
        step(C_DEQ, 32'h0);
        step(C_DEQ, 32'h0);
        step(C_DEQ, 32'h0);
        check("t6_wrap_empty", 32'(buffer), 32'h0);
        check("t6_wrap_done", 32'(done), 32'h1);

        op     = C_NOP;
        @(negedge clk);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/traffic_gen.md
TRAFFIC_GEN -- requirements
Module: traffic_gen

Interface
REQ-001 SHALL have parameter NUM_PACKETS, default 1024, meaning packet-descriptor queue depth.
REQ-002 SHALL have parameter DEST_W, default 14, meaning destination-field width.
REQ-003 SHALL have parameter VC_W, default 3, meaning VC-field width.
REQ-004 SHALL have parameter FLIT_W, default 10, meaning flit-count field width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port op, input, 4 bits: opcode (NOP=0, Init=5, Fill=6, Dequeue=7, PreDeque=8); all other codes act as NOP.
REQ-008 SHALL have port data, input, 32 bits: Init uses total [31:22]; Fill uses Dst [13:0], Vc [16:14], NumFlit [26:17].
REQ-009 SHALL have port done, output, 1 bit: all expected packets fully emitted.
REQ-010 SHALL have port buffer, output, 20 bits: presented flit with fields Full [0], Vc [3:1], Head [4], Tail [5], Dst [19:6].

Function
REQ-011 SHALL sample op and data on each rising clk edge; every op's effect SHALL be visible on buffer/done one cycle later (registered outputs).
REQ-012 Init: SHALL load total from data[31:22], clear the queue, sent count and flit counter, and clear buffer.Full.
REQ-013 Fill: SHALL push {Dst, Vc, NumFlit} into the queue tail; when the queue is full, SHALL drop the push and leave state unchanged.
REQ-014 PreDeque: if buffer.Full=0 and the queue is non-empty, SHALL present the head packet's first flit (Full=1, Head=1, Tail=(NumFlit<=1), Vc, Dst) with flit counter=1; otherwise no effect.
REQ-015 Dequeue with Full=1 and Tail=0: SHALL increment the flit counter and present the next flit (Head=0, Tail=1 when counter reaches NumFlit).
REQ-016 Dequeue with Full=1 and Tail=1: SHALL pop the packet and increment the sent count; it SHALL present the next packet's head flit if the queue is non-empty, else clear Full.
REQ-017 Dequeue with Full=0: SHALL have no effect.
REQ-018 NumFlit=0 SHALL be treated as 1 (single flit, Head=Tail=1).
REQ-019 When Full=0, the other buffer fields SHALL be 0.
REQ-020 done SHALL equal (sent count == total) AND (Full==0); total=0 after Init gives done=1 the next cycle.
REQ-021 Sent count SHALL be 10 bits and saturate at 1023; queue pointers SHALL wrap modulo NUM_PACKETS, with a separate occupancy count distinguishing full from empty.
REQ-022 Fill while a flit is presented SHALL not alter buffer.

Reset
REQ-023 rst_n=0 SHALL immediately clear the queue, pointers, occupancy, flit counter, sent count and total, and set buffer=0 and done=1.
REQ-024 Reset asserted mid-packet SHALL abandon the packet; after release, no flit SHALL be presented until a PreDeque.

Structure
REQ-025 Opcodes, the data field ranges, and the buffer field ranges SHALL live in a shared package (noc_pkg) also used by router and main.
REQ-026 The descriptor queue SHALL be one sub-module, packet_fifo (synchronous, single clock, push/pop/empty/full/head-data, asynchronous active-low reset).

Verification
REQ-027 Init total=1; Fill {Dst=3, Vc=2, NumFlit=3}; PreDeque -> buffer Full=1, Head=1, Tail=0, Vc=2, Dst=3; two Dequeues -> Tail=1 on the 2nd; third Dequeue -> Full=0, done=1.
REQ-028 Init total=2; Fill {Dst=1, NumFlit=1}, {Dst=5, NumFlit=2}; PreDeque -> Head=Tail=1, Dst=1; Dequeue -> Head=1, Tail=0, Dst=5; done=0 until the final Dequeue.
REQ-029 Init total=0 -> done=1 the next cycle; Dequeue/PreDeque -> buffer stays 0.
REQ-030 1025 Fills after Init -> 1025th dropped (occupancy 1024); drain all, order preserved, pointers wrap correctly.
REQ-031 rst_n low mid-packet (between Dequeues) -> buffer=0, done=1 asynchronously; PreDeque after release -> no flit (queue empty).
REQ-032 Dequeue with Full=0, and an undefined opcode (e.g. 3) -> no state change.
